// File: rtl/alu_pkg.sv
// Shared opcode encoding and default width for the alu block.
package alu_pkg;

   localparam int ALU_NIO_DEFAULT = 8;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SRA = 3'b101,
      OP_SLL = 3'b110,
      OP_SLT = 3'b111
   } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational NIO-bit adder/subtractor shared by ADD, SUB and SLT.
module alu_addsub
   import alu_pkg::*;
#(
   parameter int NIO = ALU_NIO_DEFAULT
) (
   input  logic [NIO-1:0] a,
   input  logic [NIO-1:0] b,
   input  logic           sub,
   output logic [NIO-1:0] sum,
   output logic           ov,
   output logic           lt
);

   logic [NIO-1:0] bb;

   assign bb  = sub ? ~b : b;
   assign sum = a + bb + {{(NIO-1){1'b0}}, sub};
   // Signed overflow: effective operands share a sign that the result lost.
   assign ov  = (a[NIO-1] == bb[NIO-1]) && (sum[NIO-1] != a[NIO-1]);
   // True sign of a-b; meaningful only while sub is high.
   assign lt  = sum[NIO-1] ^ ov;

endmodule

// File: rtl/alu.sv
// Signed two-operand ALU with registered result and overflow flag.
// Build macro ALU_SATURATE_EN: ADD/SUB/SLL clamp to the signed range on overflow.
module alu
   import alu_pkg::*;
#(
   parameter int NIO = ALU_NIO_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NIO-1:0] A,
   input  logic [NIO-1:0] B,
   input  logic [2:0]     OP,
   output logic [NIO-1:0] Z,
   output logic           OV
);

`ifdef ALU_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam logic [NIO-1:0] SMAX = {1'b0, {(NIO-1){1'b1}}};
   localparam logic [NIO-1:0] SMIN = {1'b1, {(NIO-1){1'b0}}};

   // Handshake: none. A, B and OP are sampled on every rising edge and the
   // matching Z/OV are valid one cycle later; every cycle carries an operation.
   alu_op_e        op_e;
   logic [NIO-1:0] as_sum;
   logic           as_ov;
   logic           as_lt;
   logic           as_sub;
   logic [NIO-1:0] z_d;
   logic           ov_d;
   logic           sat_neg;

   assign op_e   = alu_op_e'(OP);
   assign as_sub = (op_e != OP_ADD);

   alu_addsub #(.NIO(NIO)) u_addsub (
      .a   (A),
      .b   (B),
      .sub (as_sub),
      .sum (as_sum),
      .ov  (as_ov),
      .lt  (as_lt)
   );

   always_comb begin
      z_d     = '0;
      ov_d    = 1'b0;
      sat_neg = 1'b0;
      case (op_e)
         OP_ADD, OP_SUB: begin
            z_d     = as_sum;
            ov_d    = as_ov;
            sat_neg = A[NIO-1];
         end
         OP_AND: z_d = A & B;
         OP_OR:  z_d = A | B;
         OP_XOR: z_d = A ^ B;
         OP_SRA: z_d = {B[NIO-1], B[NIO-1:1]};
         OP_SLL: begin
            z_d     = {B[NIO-2:0], 1'b0};
            ov_d    = B[NIO-1] ^ B[NIO-2];
            sat_neg = B[NIO-1];
         end
         OP_SLT: z_d = {{(NIO-1){1'b0}}, as_lt};
         default: z_d = '0;
      endcase
      // On overflow the true result's sign is that of A (add/sub) or B (shift).
      if (SAT && ov_d) z_d = sat_neg ? SMIN : SMAX;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Z  <= '0;
         OV <= 1'b0;
      end else begin
         Z  <= z_d;
         OV <= ov_d;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases plus random ops vs an integer model.
module tb_alu;

   localparam int NIO  = 8;
   localparam int MAXV = 2**(NIO-1) - 1;
   localparam int MINV = -(2**(NIO-1));

`ifdef ALU_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NIO-1:0] A = '0;
   logic [NIO-1:0] B = '0;
   logic [2:0]     OP = '0;
   logic [NIO-1:0] Z;
   logic           OV;

   int n_vec = 0;
   int n_bad = 0;
   logic [NIO:0] exp_q[$];

   alu #(.NIO(NIO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .OP    (OP),
      .Z     (Z),
      .OV    (OV)
   );

   always #5 clk = ~clk;

   // Reference: exact integer result, then range check / clamp / wrap.
   function automatic logic [NIO:0] model(input logic [2:0] op, input logic [NIO-1:0] a,
                                           input logic [NIO-1:0] b);
      int sa, sb, r;
      logic ov;
      logic [NIO-1:0] z;
      sa = $signed(a);
      sb = $signed(b);
      ov = 1'b0;
      z  = '0;
      case (op)
         3'd0, 3'd1, 3'd6: begin
            if (op == 3'd0) r = sa + sb;
            else if (op == 3'd1) r = sa - sb;
            else r = sb * 2;
            ov = (r > MAXV) || (r < MINV);
            if (SAT && ov) r = (r > MAXV) ? MAXV : MINV;
            z = r[NIO-1:0];
         end
         3'd2: z = a & b;
         3'd3: z = a | b;
         3'd4: z = a ^ b;
         3'd5: begin
            r = sb >>> 1;
            z = r[NIO-1:0];
         end
         default: z = (sa < sb) ? 1 : 0;
      endcase
      return {ov, z};
   endfunction

   task automatic drive(input logic [2:0] op, input logic [NIO-1:0] a, input logic [NIO-1:0] b);
      @(negedge clk);
      OP = op;
      A  = a;
      B  = b;
      exp_q.push_back(model(op, a, b));
   endtask

   task automatic test_reset;
      logic [NIO:0] exp;
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         OP = 3'($urandom_range(0, 7));
         A  = NIO'($urandom);
         B  = NIO'($urandom);
         #1;
         n_vec++;
         if (Z !== '0 || OV !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: Z=%h OV=%b, expected Z=0 OV=0", Z, OV);
         end
      end
      drive(3'd0, 8'd20, 8'd30);
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (Z !== '0) begin
         n_bad++;
         $display("FAIL reset_release_early: Z=%h, expected 0 before first edge", Z);
      end
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      n_vec++;
      if ({OV, Z} !== exp || Z !== 8'd50) begin
         n_bad++;
         $display("FAIL reset_first_result: OV=%b Z=%h, expected OV=%b Z=%h", OV, Z, exp[NIO], exp[NIO-1:0]);
      end
      // Mid-stream assertion: in-flight op is dropped and Z clears without a clock.
      drive(3'd4, 8'hA5, 8'h0F);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (Z !== '0 || OV !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_async: Z=%h OV=%b, expected 0/0", Z, OV);
      end
      void'(exp_q.pop_front());
      @(posedge clk);
      #1;
      n_vec++;
      if (Z !== '0) begin
         n_bad++;
         $display("FAIL reset_discard: Z=%h, expected 0", Z);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_sra;
      logic [NIO:0] exp;
      logic [NIO-1:0] bv;
      for (int i = 0; i < 23; i++) begin
         if (i == 0) bv = 8'h81;
         else if (i == 1) bv = 8'h7F;
         else if (i == 2) bv = 8'hFF;
         else bv = NIO'($urandom);
         @(negedge clk);
         OP = 3'd5;
         A  = 'z;
         B  = bv;
         exp = model(3'd5, 'z, bv);
         @(posedge clk);
         #1;
         n_vec++;
         if ({OV, Z} !== exp) begin
            n_bad++;
            $display("FAIL sra B=%h: OV=%b Z=%h, expected OV=%b Z=%h", bv, OV, Z, exp[NIO], exp[NIO-1:0]);
         end
      end
      n_vec++;
      if ((model(3'd5, 'z, 8'h81) !== {1'b0, 8'hC0}) || (model(3'd5, 'z, 8'hFF) !== {1'b0, 8'hFF})) begin
         n_bad++;
         $display("FAIL sra_model: reference disagrees with documented examples");
      end
   endtask

   task automatic test_arith;
      logic [NIO-1:0] want;
      drive(3'd0, 8'd100, 8'd50);
      @(posedge clk);
      #1;
      void'(exp_q.pop_front());
      want = SAT ? 8'd127 : 8'h96;
      n_vec++;
      if (Z !== want || OV !== 1'b1) begin
         n_bad++;
         $display("FAIL add_ovf: OV=%b Z=%h, expected OV=1 Z=%h", OV, Z, want);
      end
      drive(3'd0, 8'd20, 8'd30);
      @(posedge clk);
      #1;
      void'(exp_q.pop_front());
      n_vec++;
      if (Z !== 8'd50 || OV !== 1'b0) begin
         n_bad++;
         $display("FAIL add_plain: OV=%b Z=%h, expected OV=0 Z=32", OV, Z);
      end
      drive(3'd1, 8'h80, 8'd1);
      @(posedge clk);
      #1;
      void'(exp_q.pop_front());
      want = SAT ? 8'h80 : 8'h7F;
      n_vec++;
      if (Z !== want || OV !== 1'b1) begin
         n_bad++;
         $display("FAIL sub_ovf: OV=%b Z=%h, expected OV=1 Z=%h", OV, Z, want);
      end
   endtask

   task automatic test_logic_slt;
      logic [2:0]     ops [5] = '{3'd2, 3'd3, 3'd4, 3'd7, 3'd7};
      logic [NIO-1:0] av  [5] = '{8'hF0, 8'hF0, 8'hF0, 8'hFB, 8'h03};
      logic [NIO-1:0] bv  [5] = '{8'h3C, 8'h3C, 8'h3C, 8'h03, 8'hFB};
      logic [NIO-1:0] zv  [5] = '{8'h30, 8'hFC, 8'hCC, 8'h01, 8'h00};
      for (int i = 0; i < 5; i++) begin
         drive(ops[i], av[i], bv[i]);
         @(posedge clk);
         #1;
         void'(exp_q.pop_front());
         n_vec++;
         if (Z !== zv[i] || OV !== 1'b0) begin
            n_bad++;
            $display("FAIL logic_slt[%0d] op=%0d: OV=%b Z=%h, expected OV=0 Z=%h", i, ops[i], OV, Z, zv[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [NIO:0] exp;
      for (int i = 0; i < 200; i++) begin
         drive(3'(i % 8), NIO'($urandom), NIO'($urandom));
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         n_vec++;
         if ({OV, Z} !== exp) begin
            n_bad++;
            $display("FAIL back_to_back[%0d] op=%0d: OV=%b Z=%h, expected OV=%b Z=%h",
                     i, i % 8, OV, Z, exp[NIO], exp[NIO-1:0]);
         end
      end
   endtask

   task automatic test_random;
      logic [NIO:0] exp;
      for (int i = 0; i < 300; i++) begin
         drive(3'($urandom_range(0, 7)), NIO'($urandom), NIO'($urandom));
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         n_vec++;
         if ({OV, Z} !== exp) begin
            n_bad++;
            $display("FAIL random[%0d] op=%0d A=%h B=%h: OV=%b Z=%h, expected OV=%b Z=%h",
                     i, OP, A, B, OV, Z, exp[NIO], exp[NIO-1:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_sra();
      test_arith();
      test_logic_slt();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
